// File: rtl/pw_pkg.sv
// Shared defaults, FSM state type and byte-slice helpers for the password stepper.
// Helpers work on a fixed 64-byte bus; callers widen and narrow with casts.
package pw_pkg;

  localparam logic [7:0]  PW_CHAR_MIN  = 8'h20;
  localparam logic [7:0]  PW_CHAR_MAX  = 8'h7E;
  localparam int unsigned PW_MAX_LEN   = 20;

  localparam int unsigned PW_BUS_BYTES = 64;
  localparam int unsigned PW_BUS_W     = 8 * PW_BUS_BYTES;

  typedef logic [PW_BUS_W-1:0] pw_bus_t;

  typedef enum logic [1:0] {
    StIdle,
    StStep,
    StDone
  } pw_state_e;

  function automatic logic [7:0] pw_get_byte(input pw_bus_t bus, input logic [5:0] idx);
    return bus[8*idx +: 8];
  endfunction

  function automatic pw_bus_t pw_set_byte(input pw_bus_t bus, input logic [5:0] idx,
                                          input logic [7:0] val);
    pw_bus_t res;
    res = bus;
    res[8*idx +: 8] = val;
    return res;
  endfunction

endpackage

// File: rtl/pw_digit_add.sv
// Single base-R digit adder: adds an addend to one charset byte and reports carry
// and whether the byte was outside the charset.
module pw_digit_add
  import pw_pkg::*;
#(
  parameter logic [7:0] CHAR_MIN = PW_CHAR_MIN,
  parameter logic [7:0] CHAR_MAX = PW_CHAR_MAX
) (
  input  logic [7:0] cur_byte,
  input  logic [7:0] addend,
  output logic [7:0] new_byte,
  output logic       carry,
  output logic       range_err
);

  localparam logic [8:0] RADIX = {1'b0, CHAR_MAX} - {1'b0, CHAR_MIN} + 9'd1;

  logic [8:0] sum;

  always_comb begin
    sum       = {1'b0, cur_byte} - {1'b0, CHAR_MIN} + {1'b0, addend};
    carry     = (sum >= RADIX);
    // Result digit fits in 8 bits, so the subtraction can be done modulo 256.
    new_byte  = CHAR_MIN + (carry ? (sum[7:0] - RADIX[7:0]) : sum[7:0]);
    range_err = (cur_byte < CHAR_MIN) || (cur_byte > CHAR_MAX);
  end

endmodule

// File: rtl/pw_stepper.sv
// Adds a stride to a little-endian base-R password, growing the length on overflow.
// Optional charset/stride checking with out_error is enabled by PW_STEPPER_CHARSET_CHECK_EN.
module pw_stepper
  import pw_pkg::*;
#(
  parameter int unsigned MAX_LEN  = PW_MAX_LEN,
  parameter logic [7:0]  CHAR_MIN = PW_CHAR_MIN,
  parameter logic [7:0]  CHAR_MAX = PW_CHAR_MAX,
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*MAX_LEN-1:0] in_password,
  input  logic [LEN_W-1:0]     in_length,
  input  logic [7:0]           in_step,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*MAX_LEN-1:0] out_password,
  output logic [LEN_W-1:0]     out_length,
  output logic                 out_exhausted
`ifdef PW_STEPPER_CHARSET_CHECK_EN
  ,
  output logic                 out_error
`endif
);

  localparam int unsigned      PW_W      = 8 * MAX_LEN;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
`ifdef PW_STEPPER_CHARSET_CHECK_EN
  localparam logic [8:0]       RADIX     = {1'b0, CHAR_MAX} - {1'b0, CHAR_MIN} + 9'd1;
`endif

  pw_state_e        state;
  logic [LEN_W-1:0] index;
  logic [7:0]       addend;
  logic [PW_W-1:0]  save_password;
  logic [LEN_W-1:0] save_length;

  logic [7:0]      cur_byte;
  logic [7:0]      new_byte;
  logic            carry;
  logic            digit_err;
  logic            at_top;
  pw_bus_t         bus_wide;
  logic [PW_W-1:0] pw_stepped;
  logic [PW_W-1:0] pw_grown;
  logic [PW_W-1:0] pw_first;

  assign bus_wide   = PW_BUS_W'(out_password);
  assign cur_byte   = pw_get_byte(bus_wide, 6'(index));
  assign pw_stepped = PW_W'(pw_set_byte(bus_wide, 6'(index), new_byte));
  // Top overflow writes the wrapped digit and a fresh zero digit above it together.
  assign pw_grown   = PW_W'(pw_set_byte(PW_BUS_W'(pw_stepped), 6'(index) + 6'd1, CHAR_MIN));
  assign pw_first   = PW_W'(pw_set_byte(bus_wide, 6'd0, CHAR_MIN + addend - 8'd1));
  assign at_top     = (index == out_length - LEN_W'(1));

  pw_digit_add #(
    .CHAR_MIN (CHAR_MIN),
    .CHAR_MAX (CHAR_MAX)
  ) u_digit_add (
    .cur_byte  (cur_byte),
    .addend    (addend),
    .new_byte  (new_byte),
    .carry     (carry),
    .range_err (digit_err)
  );

`ifndef PW_STEPPER_CHARSET_CHECK_EN
  logic unused_digit_err;
  assign unused_digit_err = digit_err;
`endif

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state         <= StIdle;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_password  <= '0;
      out_length    <= '0;
      out_exhausted <= 1'b0;
      index         <= '0;
      addend        <= '0;
      save_password <= '0;
      save_length   <= '0;
`ifdef PW_STEPPER_CHARSET_CHECK_EN
      out_error     <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            out_password  <= in_password;
            out_length    <= in_length;
            save_password <= in_password;
            save_length   <= in_length;
            addend        <= in_step;
            index         <= '0;
            out_exhausted <= 1'b0;
            in_ready      <= 1'b0;
`ifdef PW_STEPPER_CHARSET_CHECK_EN
            out_error     <= 1'b0;
            if ({1'b0, in_step} >= RADIX) begin
              out_error <= 1'b1;
              state     <= StDone;
            end else
`endif
            if (in_step == 8'd0) begin
              state <= StDone;
            end else begin
              state <= StStep;
            end
          end
        end

        StStep: begin
`ifdef PW_STEPPER_CHARSET_CHECK_EN
          if ((out_length != '0) && digit_err) begin
            out_password <= save_password;
            out_length   <= save_length;
            out_error    <= 1'b1;
            state        <= StDone;
          end else
`endif
          if (out_length == '0) begin
            // Empty string plus s is the s-th single-character string.
            out_password <= pw_first;
            out_length   <= LEN_W'(1);
            state        <= StDone;
          end else if (!carry) begin
            out_password <= pw_stepped;
            state        <= StDone;
          end else if (!at_top) begin
            out_password <= pw_stepped;
            addend       <= 8'd1;
            index        <= index + LEN_W'(1);
          end else if (out_length != MAX_LEN_L) begin
            out_password <= pw_grown;
            out_length   <= out_length + LEN_W'(1);
            state        <= StDone;
          end else begin
            out_password  <= save_password;
            out_length    <= save_length;
            out_exhausted <= 1'b1;
            state         <= StDone;
          end
        end

        StDone: begin
          // out_valid rises one cycle after entering DONE.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= StIdle;
          end
        end

        default: begin
          state    <= StIdle;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pw_stepper.sv
// Directed bench for pw_stepper (MAX_LEN=4) with an ordinal-arithmetic reference model.
module tb_pw_stepper;

  localparam int     ML = 4;
  localparam int     LW = $clog2(ML + 1);
  localparam int     PW = 8 * ML;
  localparam longint R  = 95;

  logic          clk = 1'b0;
  logic          nrst;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_password;
  logic [LW-1:0] in_length;
  logic [7:0]    in_step;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_password;
  logic [LW-1:0] out_length;
  logic          out_exhausted;
  logic          dut_err;

  always #5 clk = ~clk;

  pw_stepper #(
    .MAX_LEN (ML)
  ) dut (
    .clk           (clk),
    .nrst          (nrst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_password   (in_password),
    .in_length     (in_length),
    .in_step       (in_step),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_password  (out_password),
    .out_length    (out_length),
    .out_exhausted (out_exhausted)
`ifdef PW_STEPPER_CHARSET_CHECK_EN
    ,
    .out_error     (dut_err)
`endif
  );

`ifndef PW_STEPPER_CHARSET_CHECK_EN
  assign dut_err = 1'b0;
`endif

  typedef struct {
    logic [PW-1:0] pw;
    logic [LW-1:0] len;
    logic [7:0]    step;
    logic [PW-1:0] epw;
    logic [LW-1:0] elen;
    bit            eexh;
    bit            eerr;
    int            lat;
    int            hold;
  } vec_t;

  vec_t vecs[$];

  int total = 0;
  int bad   = 0;
  bit busy  = 1'b0;
  bit chk_en = 1'b0;
  logic [PW-1:0] exp_pw;
  logic [LW-1:0] exp_len;
  bit exp_exh;
  bit exp_err;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Strings of length < L precede all strings of length L.
  function automatic longint offs(input int len);
    longint s = 0;
    longint p = 1;
    for (int j = 0; j < len; j++) begin
      s += p;
      p *= R;
    end
    return s;
  endfunction

  function automatic bit out_of_set(input logic [7:0] b);
    return (b < 8'h20) || (b > 8'h7E);
  endfunction

  task automatic model(input logic [PW-1:0] pw, input logic [LW-1:0] len,
                       input logic [7:0] step, output logic [PW-1:0] opw,
                       output logic [LW-1:0] olen, output bit oexh, output bit oerr);
    longint n;
    longint v;
    longint p;
    int     nl;
    opw  = pw;
    olen = len;
    oexh = 1'b0;
    oerr = 1'b0;
`ifdef PW_STEPPER_CHARSET_CHECK_EN
    if (longint'(step) >= R) oerr = 1'b1;
    else begin
      v = longint'(step);
      for (int i = 0; i < int'(len); i++) begin
        if (out_of_set(pw[8*i +: 8])) begin
          oerr = 1'b1;
          break;
        end
        if (longint'(pw[8*i +: 8]) - 32 + v < R) break;
        v = 1;
      end
    end
    if (oerr) return;
`endif
    if (step == 8'd0) return;
    v = 0;
    p = 1;
    for (int i = 0; i < int'(len); i++) begin
      v += (longint'(pw[8*i +: 8]) - 32) * p;
      p *= R;
    end
    n = offs(int'(len)) + v + longint'(step);
    if (n >= offs(ML + 1)) begin
      oexh = 1'b1;
      return;
    end
    nl = 0;
    while (nl < ML && n >= offs(nl + 1)) nl++;
    v = n - offs(nl);
    for (int i = 0; i < nl; i++) begin
      opw[8*i +: 8] = 8'(32 + (v % R));
      v = v / R;
    end
    olen = LW'(nl);
  endtask

  // Compare process: handshake and result checked on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 64'(in_ready), 64'(!busy));
      if (!busy) check("out_valid_idle", 64'(out_valid), 64'd0);
      else if (out_valid)
        check("result", 64'({dut_err, out_exhausted, out_length, out_password}),
              64'({exp_err, exp_exh, exp_len, exp_pw}));
    end
  end

  task automatic run(input vec_t v);
    logic [PW-1:0] mpw;
    logic [LW-1:0] mlen;
    bit            mexh;
    bit            merr;
    int            cnt;
    model(v.pw, v.len, v.step, mpw, mlen, mexh, merr);
    check("model_pin", 64'({merr, mexh, mlen, mpw}), 64'({v.eerr, v.eexh, v.elen, v.epw}));
    @(negedge clk);
    in_password = v.pw;
    in_length   = v.len;
    in_step     = v.step;
    in_valid    = 1'b1;
    exp_pw      = mpw;
    exp_len     = mlen;
    exp_exh     = mexh;
    exp_err     = merr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    busy     = 1'b1;
    cnt = 0;
    while (cnt < 40) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (out_valid) break;
    end
    check("latency", 64'(cnt), 64'(v.lat));
    repeat (v.hold) @(negedge clk);
    if (v.hold > 0) check("held_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    busy      = 1'b0;
    @(negedge clk);
    check("released", 64'(out_valid), 64'd0);
  endtask

  initial begin
    nrst        = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    in_password = '0;
    in_length   = '0;
    in_step     = '0;

    vecs.push_back('{32'h00000061, 3'd1, 8'd1,  32'h00000062, 3'd1, 1'b0, 1'b0, 2, 0});
    vecs.push_back('{32'h00007E7E, 3'd2, 8'd1,  32'h00202020, 3'd3, 1'b0, 1'b0, 3, 0});
    vecs.push_back('{32'h00000000, 3'd0, 8'd5,  32'h00000024, 3'd1, 1'b0, 1'b0, 2, 0});
    vecs.push_back('{32'h00007E7D, 3'd2, 8'd3,  32'h00202021, 3'd3, 1'b0, 1'b0, 3, 0});
    vecs.push_back('{32'h7E7E7E7E, 3'd4, 8'd1,  32'h7E7E7E7E, 3'd4, 1'b1, 1'b0, 5, 0});
    vecs.push_back('{32'h00004142, 3'd2, 8'd0,  32'h00004142, 3'd2, 1'b0, 1'b0, 1, 0});
    vecs.push_back('{32'hAB006141, 3'd2, 8'd10, 32'hAB00614B, 3'd2, 1'b0, 1'b0, 2, 0});
    vecs.push_back('{32'h00207E7E, 3'd3, 8'd2,  32'h00212021, 3'd3, 1'b0, 1'b0, 4, 0});
    vecs.push_back('{32'h557E7E7E, 3'd3, 8'd94, 32'h2020207D, 3'd4, 1'b0, 1'b0, 4, 0});
    vecs.push_back('{32'h00000061, 3'd1, 8'd1,  32'h00000062, 3'd1, 1'b0, 1'b0, 2, 5});
`ifdef PW_STEPPER_CHARSET_CHECK_EN
    vecs.push_back('{32'h00000019, 3'd1, 8'd1,  32'h00000019, 3'd1, 1'b0, 1'b1, 2, 0});
    vecs.push_back('{32'h00000061, 3'd1, 8'd95, 32'h00000061, 3'd1, 1'b0, 1'b1, 1, 0});
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 64'({dut_err, in_ready, out_valid, out_exhausted, out_length, out_password}),
          64'({1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0}));
    nrst   = 1'b1;
    chk_en = 1'b1;

    foreach (vecs[i]) run(vecs[i]);

    // Reset while stepping through a four-digit carry chain.
    @(negedge clk);
    in_password = 32'h207E7E7E;
    in_length   = 3'd4;
    in_step     = 8'd1;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    busy     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    busy = 1'b0;
    @(negedge clk);
    check("mid_reset", 64'({out_valid, out_exhausted, out_length, out_password}), 64'd0);
    repeat (8) @(negedge clk);

    run(vecs[0]);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
